nrzi_unstuff: RTL



---
 rtl/usb_rx_pkg.sv | 20 ++
 rtl/nrzi_dec.sv | 35 +++
 rtl/nrzi_unstuff.sv | 134 +++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// +-----------------------------------------------------------------------+
// | usb_rx_pkg : shared receive-path constants and FSM state encoding      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

package usb_rx_pkg;

    localparam int STUFF_RUN_DEF = 6;
    localparam int MAX_PKT_BITS  = 88;

    typedef logic [1:0] rx_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/nrzi_dec.sv
// +-----------------------------------------------------------------------+
// | nrzi_dec : NRZI line-level decoder with load-to-0 of the prior level   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module nrzi_dec (
    input  logic clk,
    input  logic rst_b,
    input  logic i_level,
    input  logic i_en,
    input  logic i_load0,
    output logic o_bit
);

    logic r_prev;
    logic w_ref;

    // On packet entry the reference is the trailing SYNC K, i.e. level 0.
    assign w_ref = i_load0 ? 1'b0 : r_prev;
    assign o_bit = ~(i_level ^ w_ref);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_prev <= 1'b0;
        end else if (i_en) begin
            r_prev <= i_level;
        end else if (i_load0) begin
            r_prev <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/nrzi_unstuff.sv
// +-----------------------------------------------------------------------+
// | nrzi_unstuff : NRZI decode and bit-unstuffing of received USB packets  |
// | Optional stuff-violation error path: define UNSTUFF_ERR_EN. Rev 1.0    |
// +-----------------------------------------------------------------------+
`default_nettype none

module nrzi_unstuff
    import usb_rx_pkg::*;
#(
    parameter int STUFF_RUN = STUFF_RUN_DEF,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bstr,
    input  logic             bstr_ready,
    input  logic             done,
    output logic             dout,
    output logic             dout_valid,
    output logic             eop,
    output logic             err,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int               ONES_W    = $clog2(STUFF_RUN + 1);
    localparam logic [ONES_W-1:0] C_RUN     = ONES_W'(STUFF_RUN);
    localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;

    rx_state_t         r_state;
    logic              r_armed;
    logic [ONES_W-1:0] r_ones;
    logic              r_dout;
    logic              r_dout_valid;
    logic              r_eop;
    logic [CNT_W-1:0]  r_bit_cnt;

    logic              w_start;
    logic              w_accept;
    logic              w_dec;
    logic              w_at_run;
    logic              w_emit;
    logic [ONES_W-1:0] w_ones;
    logic [ONES_W-1:0] w_ones_nxt;
    logic [CNT_W-1:0]  w_cnt;

    // A packet is only accepted once the line has been seen idle since reset.
    assign w_start  = (r_state == ST_IDLE) && bstr_ready && r_armed;
    assign w_accept = w_start || ((r_state == ST_RECV) && bstr_ready && !done);

    nrzi_dec u_nrzi_dec (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_level (bstr),
        .i_en    (w_accept),
        .i_load0 (w_start),
        .o_bit   (w_dec)
    );

    assign w_ones   = w_start ? '0 : r_ones;
    assign w_cnt    = w_start ? '0 : r_bit_cnt;
    assign w_at_run = (w_ones == C_RUN);

`ifdef UNSTUFF_ERR_EN
    assign w_emit = w_accept && !w_at_run;
`else
    assign w_emit = w_accept && !(w_at_run && !w_dec);
`endif

    // After a full run the count sticks at STUFF_RUN on further 1s.
    assign w_ones_nxt = !w_dec  ? '0 :
                        w_at_run ? w_ones : (w_ones + ONES_W'(1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= ST_IDLE;
            r_armed      <= 1'b0;
            r_ones       <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_eop        <= 1'b0;
            r_bit_cnt    <= '0;
        end else begin
            r_dout_valid <= w_emit;
            r_eop        <= 1'b0;
            if (!bstr_ready) begin
                r_armed <= 1'b1;
            end
            if (w_start) begin
                r_state <= ST_RECV;
            end else if ((r_state != ST_IDLE) && done) begin
                r_state <= ST_IDLE;
                r_eop   <= 1'b1;
            end
`ifdef UNSTUFF_ERR_EN
            if (w_accept && w_dec && w_at_run) begin
                r_state <= ST_ERR;
            end
`endif
            if (w_accept) begin
                r_ones    <= w_ones_nxt;
                r_bit_cnt <= (w_emit && (w_cnt != C_CNT_MAX)) ? (w_cnt + CNT_W'(1)) : w_cnt;
            end
            if (w_emit) begin
                r_dout <= w_dec;
            end
        end
    end

`ifdef UNSTUFF_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_err <= 1'b0;
        end else if (w_accept && w_dec && w_at_run) begin
            r_err <= 1'b1;
        end else if (w_start) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign eop        = r_eop;
    assign bit_cnt    = r_bit_cnt;

endmodule

`default_nettype wire
